muldiv_unit: RTL

- Iterative multiply/divide unit implementing the RV32M operations. It is the multi-cycle companion to the single-cycle integer ALU in the execute stage.
- Takes the same operand pair plus an M-extension opcode, and returns a 32-bit result through a valid/ready handshake.
- Execute stalls on `ready_o`/`valid_o`, and `flush` abandons an operation on branch mispredict or trap.

---
 rtl/muldiv_unit_pkg.sv | 23 ++
 rtl/muldiv_unit_iter.sv | 29 ++
 rtl/muldiv_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: opcodes (funct3) and FSM states.
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL_OP    = 3'b000;
  localparam logic [2:0] MD_MULH_OP   = 3'b001;
  localparam logic [2:0] MD_MULHSU_OP = 3'b010;
  localparam logic [2:0] MD_MULHU_OP  = 3'b011;
  localparam logic [2:0] MD_DIV_OP    = 3'b100;
  localparam logic [2:0] MD_DIVU_OP   = 3'b101;
  localparam logic [2:0] MD_REM_OP    = 3'b110;
  localparam logic [2:0] MD_REMU_OP   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_iter.sv
// One combinational step of the iterative datapath: shift-add multiply or restoring divide
// over a 2*XLEN accumulator ({hi, lo}).
module muldiv_iter_step
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0] sum;
  logic [XLEN:0] diff;

  // Divide: the shifted partial remainder needs XLEN+1 bits, so the trial subtract is one bit wider.
  always_comb begin
    sum  = {1'b0, acc_in[2*XLEN-1:XLEN]} + {1'b0, {XLEN{acc_in[0]}} & opnd};
    diff = acc_in[2*XLEN-1:XLEN-1] - {1'b0, opnd};
    if (div) begin
      if (diff[XLEN]) acc_out = {acc_in[2*XLEN-2:0], 1'b0};
      else            acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
    end else begin
      acc_out = {sum, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready handshake and flush.
// Optional MULDIV_FAST_MUL_EN: multiplies use one combinational multiplier and finish in one cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ITER_BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      mdop,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] y
);

  localparam int STEPS = XLEN / ITER_BITS;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  md_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0] opnd;
  logic neg_q, neg_r;
  logic accept, calc_last, special;
  logic signed_a, signed_b, a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b, special_y, result;
  logic [XLEN-1:0] quot_fix, rem_fix;
  logic [2*XLEN-1:0] acc_fin, prod_fix;
  logic [ITER_BITS:0][2*XLEN-1:0] chain;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    unique case (mdop)
      MD_MULH_OP, MD_DIV_OP, MD_REM_OP: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      MD_MULHSU_OP: signed_a = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = signed_a & a[XLEN-1];
  assign b_neg = signed_b & b[XLEN-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0] fast_a, fast_b;
  logic [2*XLEN-1:0] fast_p;
  assign fast_a = {signed_a & a[XLEN-1], a};
  assign fast_b = {signed_b & b[XLEN-1], b};
  assign fast_p = (2*XLEN)'(fast_a * fast_b);
`endif

  // Results that bypass CALC: divide by zero, signed overflow, and (optionally) all multiplies.
  always_comb begin
    special   = 1'b0;
    special_y = '0;
    if (md_is_div(mdop)) begin
      if (b == '0) begin
        special   = 1'b1;
        special_y = mdop[1] ? a : '1;
      end else if (!mdop[0] && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1) begin
        special   = 1'b1;
        special_y = mdop[1] ? '0 : a;
      end
    end
`ifdef MULDIV_FAST_MUL_EN
    else begin
      special   = 1'b1;
      special_y = (mdop[1:0] == 2'b00) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif
  end

  assign chain[0] = acc;
  for (genvar i = 0; i < ITER_BITS; i++) begin : g_step
    muldiv_iter_step #(.XLEN(XLEN)) u_step (
      .div    (md_is_div(op)),
      .acc_in (chain[i]),
      .opnd   (opnd),
      .acc_out(chain[i+1])
    );
  end
  assign acc_fin = chain[ITER_BITS];

  assign prod_fix = neg_q ? -acc_fin : acc_fin;
  assign quot_fix = neg_q ? -acc_fin[XLEN-1:0] : acc_fin[XLEN-1:0];
  assign rem_fix  = neg_r ? -acc_fin[2*XLEN-1:XLEN] : acc_fin[2*XLEN-1:XLEN];

  always_comb begin
    unique case (op)
      MD_MUL_OP:                             result = prod_fix[XLEN-1:0];
      MD_MULH_OP, MD_MULHSU_OP, MD_MULHU_OP: result = prod_fix[2*XLEN-1:XLEN];
      MD_DIV_OP, MD_DIVU_OP:                 result = quot_fix;
      default:                               result = rem_fix;
    endcase
  end

  assign accept    = valid_i & ready_o & ~flush;
  assign calc_last = (state == CALC) && (cnt == CNT_W'(STEPS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (valid_i) state_nxt = special ? DONE : CALC;
        CALC:    if (calc_last) state_nxt = DONE;
        DONE:    if (ready_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o = (state == IDLE);
    valid_o = (state == DONE);
  end

  // Operand capture at accept; iteration and sign fixup while in CALC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      op    <= '0;
      acc   <= '0;
      opnd  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      y     <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (accept) begin
      cnt   <= '0;
      op    <= mdop;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      if (md_is_div(mdop)) begin
        acc  <= {{XLEN{1'b0}}, mag_a};
        opnd <= mag_b;
      end else begin
        acc  <= {{XLEN{1'b0}}, mag_b};
        opnd <= mag_a;
      end
      if (special) y <= special_y;
    end else if (state == CALC) begin
      acc <= acc_fin;
      cnt <= cnt + 1'b1;
      if (calc_last) y <= result;
    end
  end

endmodule
